// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: ALU opcodes, multiply FSM states
// and the default multiply iteration count.
package ex_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b110;
   localparam logic [2:0] ALU_MUL = 3'b111;

   localparam int MUL_CYCLES_DEF = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/ex_stage_seq_multiplier.sv
// Shift-add unsigned multiplier: captures operands on start, then runs one
// add/shift per cycle; last flags the final iteration.
module seq_multiplier
   import ex_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int CYCLES = MUL_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] product,
   output logic             last
);

   localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [CW-1:0]    r_cnt;
   logic             r_run;

   assign last    = r_run && (r_cnt == CW'(CYCLES - 1));
   assign product = r_acc;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_run    <= 1'b0;
      end else if (start) begin
         r_acc    <= '0;
         r_mcand  <= a;
         r_mplier <= b;
         r_cnt    <= '0;
         r_run    <= 1'b1;
      end else if (r_run) begin
         if (r_mplier[0])
            r_acc <= r_acc + r_mcand;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (last)
            r_run <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, multi-cycle multiply sequencer and the
// EX/MEM pipeline register.
module ex_stage
   import ex_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             regwrite,
   input  logic             memread,
   input  logic             memwrite,
   input  logic             branch,
   input  logic             memtoreg,
   input  logic             regdst,
   input  logic             alusrc,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   input  logic [WIDTH-1:0] offset,
   input  logic [3:0]       regdest1,
   input  logic [3:0]       regdest2,
   input  logic [2:0]       aluop,
   input  logic [WIDTH-1:0] pcin,
   output logic             stall,
   output logic             regwriteout,
   output logic             memreadout,
   output logic             memwriteout,
   output logic             memtoregout,
   output logic             branchtaken,
   output logic [WIDTH-1:0] branchtarget,
   output logic [WIDTH-1:0] aluresult,
   output logic [WIDTH-1:0] storedata,
   output logic [3:0]       destreg,
   output logic             zero
);

   state_t           r_state;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_alu;
   logic [WIDTH-1:0] w_result;
   logic [WIDTH-1:0] w_product;
   logic             w_mul_last;
   logic             w_start;
   logic             w_zero;

   assign w_b      = alusrc ? offset : data2;
   assign w_start  = (r_state == S_IDLE) && (aluop == ALU_MUL);
   assign w_result = (r_state == S_DONE) ? w_product : w_alu;
   assign w_zero   = (w_result == '0);

   // Reset forces stall low even while a MUL is still held in ID/EX.
   assign stall = ~rst & (w_start | (r_state == S_BUSY));

   // NOTE: every branch of a combinational block must assign its outputs;
   // the leading default keeps synthesis from inferring a latch.
   always_comb begin
      w_alu = '0;
      unique case (aluop)
         ALU_ADD: w_alu = data1 + w_b;
         ALU_SUB: w_alu = data1 - w_b;
         ALU_AND: w_alu = data1 & w_b;
         ALU_OR:  w_alu = data1 | w_b;
         ALU_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(w_b))};
         ALU_SLL: w_alu = data1 << w_b[3:0];
         ALU_SRL: w_alu = data1 >> w_b[3:0];
         default: w_alu = '0;
      endcase
   end

   seq_multiplier #(
      .WIDTH  (WIDTH),
      .CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (w_start),
      .a       (data1),
      .b       (data2),
      .product (w_product),
      .last    (w_mul_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE:  if (aluop == ALU_MUL) r_state <= S_BUSY;
            S_BUSY:  if (w_mul_last)       r_state <= S_DONE;
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // A stalled cycle always loads a bubble; DONE reuses the held MUL controls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || stall) begin
         regwriteout  <= 1'b0;
         memreadout   <= 1'b0;
         memwriteout  <= 1'b0;
         memtoregout  <= 1'b0;
         branchtaken  <= 1'b0;
         branchtarget <= '0;
         aluresult    <= '0;
         storedata    <= '0;
         destreg      <= '0;
         zero         <= 1'b0;
      end else begin
         regwriteout  <= regwrite;
         memreadout   <= memread;
         memwriteout  <= memwrite;
         memtoregout  <= memtoreg;
         branchtaken  <= branch & w_zero;
         branchtarget <= pcin + offset;
         aluresult    <= w_result;
         storedata    <= data2;
         destreg      <= regdst ? regdest2 : regdest1;
         zero         <= w_zero;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, branch, multiply
// timing and reset during a multiply.
module tb_ex_stage;
   import ex_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        regwrite, memread, memwrite, branch, memtoreg, regdst, alusrc;
   logic [15:0] data1, data2, offset, pcin;
   logic [3:0]  regdest1, regdest2;
   logic [2:0]  aluop;
   logic        stall;
   logic        regwriteout, memreadout, memwriteout, memtoregout, branchtaken;
   logic [15:0] branchtarget, aluresult, storedata;
   logic [3:0]  destreg;
   logic        zero;

   int n_cmp = 0;
   int n_err = 0;

   ex_stage dut (
      .clk          (clk),
      .rst          (rst),
      .regwrite     (regwrite),
      .memread      (memread),
      .memwrite     (memwrite),
      .branch       (branch),
      .memtoreg     (memtoreg),
      .regdst       (regdst),
      .alusrc       (alusrc),
      .data1        (data1),
      .data2        (data2),
      .offset       (offset),
      .regdest1     (regdest1),
      .regdest2     (regdest2),
      .aluop        (aluop),
      .pcin         (pcin),
      .stall        (stall),
      .regwriteout  (regwriteout),
      .memreadout   (memreadout),
      .memwriteout  (memwriteout),
      .memtoregout  (memtoregout),
      .branchtaken  (branchtaken),
      .branchtarget (branchtarget),
      .aluresult    (aluresult),
      .storedata    (storedata),
      .destreg      (destreg),
      .zero         (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctrl();
      regwrite = 1'b0; memread = 1'b0; memwrite = 1'b0; branch = 1'b0;
      memtoreg = 1'b0; regdst  = 1'b0; pcin = 16'h0000;
      regdest1 = 4'd0; regdest2 = 4'd0;
   endtask

   task automatic put(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] off, input logic src);
      aluop = op; data1 = a; data2 = b; offset = off; alusrc = src;
   endtask

   int stall_cnt;

   initial begin
      rst = 1'b1;
      clear_ctrl();
      put(ALU_ADD, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      repeat (2) tick();
      chk("rst_aluresult", aluresult, 16'h0000);
      chk("rst_regwrite", regwriteout, 1'b0);
      chk("rst_stall", stall, 1'b0);
      rst = 1'b0;

      // ADD with signed wrap, destination from regdest2
      clear_ctrl(); regwrite = 1'b1; regdst = 1'b1; regdest1 = 4'd2; regdest2 = 4'd5;
      put(ALU_ADD, 16'h7FFF, 16'h0001, 16'h0000, 1'b0);
      tick();
      chk("add_result", aluresult, 16'h8000);
      chk("add_destreg", destreg, 4'd5);
      chk("add_regwrite", regwriteout, 1'b1);
      chk("add_zero", zero, 1'b0);

      // SUB-based branch, taken then not taken
      clear_ctrl(); branch = 1'b1; pcin = 16'h0010;
      put(ALU_SUB, 16'h1234, 16'h1234, 16'hFFFC, 1'b0);
      tick();
      chk("beq_taken", branchtaken, 1'b1);
      chk("beq_zero", zero, 1'b1);
      chk("beq_target", branchtarget, 16'h000C);
      chk("beq_regwrite", regwriteout, 1'b0);
      data2 = 16'h1235;
      tick();
      chk("bne_taken", branchtaken, 1'b0);
      chk("bne_result", aluresult, 16'hFFFF);

      // Signed compare both ways
      clear_ctrl(); regwrite = 1'b1;
      put(ALU_SLT, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
      tick();
      chk("slt_neg", aluresult, 16'h0001);
      put(ALU_SLT, 16'h0001, 16'hFFFF, 16'h0000, 1'b0);
      tick();
      chk("slt_pos", aluresult, 16'h0000);

      // Shifts by immediate; only B[3:0] counts; store data passes through
      clear_ctrl(); memwrite = 1'b1; regdest1 = 4'd9; regdest2 = 4'd3;
      put(ALU_SLL, 16'h0001, 16'hBEEF, 16'h0013, 1'b1);
      tick();
      chk("sll_result", aluresult, 16'h0008);
      chk("sll_storedata", storedata, 16'hBEEF);
      chk("sll_memwrite", memwriteout, 1'b1);
      chk("sll_destreg", destreg, 4'd9);
      put(ALU_SRL, 16'h8000, 16'h0000, 16'h000F, 1'b1);
      tick();
      chk("srl_result", aluresult, 16'h0001);

      // AND / OR with load-style controls
      clear_ctrl(); memread = 1'b1; memtoreg = 1'b1;
      put(ALU_AND, 16'hF0F0, 16'h3CC3, 16'h0000, 1'b0);
      tick();
      chk("and_result", aluresult, 16'h30C0);
      chk("and_memread", memreadout, 1'b1);
      chk("and_memtoreg", memtoregout, 1'b1);
      put(ALU_OR, 16'hF0F0, 16'h3CC3, 16'h0000, 1'b0);
      tick();
      chk("or_result", aluresult, 16'hFCF3);

      // MUL: stall cycles 0..16, bubbles 1..17, product visible in cycle 18
      clear_ctrl(); regwrite = 1'b1; regdst = 1'b1; regdest2 = 4'd7;
      put(ALU_MUL, 16'h0123, 16'h0045, 16'h0000, 1'b0);
      #1;
      chk("mul_stall_c0", stall, 1'b1);
      stall_cnt = stall ? 1 : 0;
      for (int i = 1; i <= 17; i++) begin
         tick();
         if (stall) stall_cnt++;
         chk($sformatf("mul_stall_c%0d", i), stall, (i <= 16) ? 1'b1 : 1'b0);
         chk($sformatf("mul_bubble_rw_c%0d", i), regwriteout, 1'b0);
         chk($sformatf("mul_bubble_res_c%0d", i), aluresult, 16'h0000);
      end
      chk("mul_stall_count", 16'(stall_cnt), 16'd17);
      tick();
      chk("mul_result", aluresult, 16'h4E6F);
      chk("mul_regwrite", regwriteout, 1'b1);
      chk("mul_destreg", destreg, 4'd7);
      chk("mul_zero", zero, 1'b0);
      put(ALU_ADD, 16'h0002, 16'h0003, 16'h0000, 1'b0);
      #1;
      chk("post_mul_stall", stall, 1'b0);
      tick();
      chk("post_mul_add", aluresult, 16'h0005);

      // Reset in the 8th BUSY cycle discards the multiply
      clear_ctrl(); regwrite = 1'b1;
      put(ALU_MUL, 16'h0003, 16'h0005, 16'h0000, 1'b0);
      repeat (8) tick();
      chk("rst_mid_pre_stall", stall, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_mid_stall", stall, 1'b0);
      chk("rst_mid_result", aluresult, 16'h0000);
      chk("rst_mid_regwrite", regwriteout, 1'b0);
      tick();
      chk("rst_mid_hold_stall", stall, 1'b0);
      put(ALU_ADD, 16'h0010, 16'h0020, 16'h0000, 1'b0);
      rst = 1'b0;
      #1;
      chk("rst_rel_stall", stall, 1'b0);
      tick();
      chk("rst_rel_add", aluresult, 16'h0030);
      chk("rst_rel_regwrite", regwriteout, 1'b1);
      chk("rst_rel_nostall", stall, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
